pipe_event_counters: RTL and testbench

Parametrised pipeline performance-monitor block for the RISC-V pipelined CPU. It holds NUM_EVT+1 counters: channel 0 counts active cycles, and channels 1..NUM_EVT count single-cycle event strobes such as stall, flush or retire, taken from the hazard-detection and branch logic. Software or a bench takes a coherent snapshot of all channels at once, then reads the channels back one at a time. Per-channel sticky overflow flags are kept, and each counter either wraps or saturates.

---
 rtl/pipe_event_counters.sv | 116 +++++++++++
 tb/tb_pipe_event_counters.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_event_counters.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_event_counters
//  Purpose  : Pipeline performance monitor. Channel 0 counts active cycles,
//             channels 1..NUM_EVT count single-cycle event strobes. A
//             snapshot copies every live counter into a shadow register in
//             one edge so software can read a coherent set back one channel
//             at a time. Each channel keeps a sticky overflow flag and
//             either wraps or saturates.
//  Ports    : clk_i      - clock, rising-edge active
//             rst_i      - asynchronous active-high reset
//             start_i    - global count enable
//             evt_i      - event strobes, bit k-1 feeds channel k
//             freeze_i   - holds all counters while high
//             clr_i      - synchronous clear of counters and overflow flags
//             snap_req_i - snapshot request
//             snap_ack_o - one-cycle acknowledge of an accepted snapshot
//             sel_i      - readback channel select
//             rd_data_o  - shadow[sel_i], 0 when sel_i > NUM_EVT
//             ovf_o      - sticky overflow flag per channel
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_event_counters #(
  parameter  int NUM_EVT  = 4,
  parameter  int CNT_W    = 32,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               freeze_i,
  input  logic               clr_i,
  input  logic               snap_req_i,
  output logic               snap_ack_o,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam int               NCH     = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] shd_q [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [NCH-1:0]   ovf_d;
  logic [NCH-1:0]   inc;
  logic             ack_q;
  logic             acc;

  // A request is ignored during its own ack cycle, so a held request is
  // accepted every other cycle.
  assign acc = snap_req_i & ~ack_q;

  // Channel 0 is a constant-one event: it counts every enabled cycle.
  assign inc = {evt_i, 1'b1} & {NCH{start_i & ~freeze_i}};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      ovf_d[k] = ovf_q[k];
      if (clr_i) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end else if (inc[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_d[k] = 1'b1;
          cnt_d[k] = (SATURATE != 0) ? cnt_q[k] : '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Shadows take the pre-edge counter value, so a snapshot on the same edge
  // as a clear closes one interval exactly as the next one starts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
        shd_q[k] <= '0;
      end
      ovf_q <= '0;
      ack_q <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (acc) begin
          shd_q[k] <= cnt_q[k];
        end
      end
      ovf_q <= ovf_d;
      ack_q <= acc;
    end
  end

  // Compare-based mux keeps out-of-range selects returning zero without
  // indexing past the array.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        rd_data_o = shd_q[k];
      end
    end
  end

  assign snap_ack_o = ack_q;
  assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_event_counters.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pipe_event_counters
//  Purpose  : Self-checking bench for pipe_event_counters. Three instances
//             share one stimulus stream: 32-bit wrap, 4-bit wrap and 4-bit
//             saturate. The reference model tracks the true number of
//             increments since the last clear per channel and maps it onto
//             each instance's width and overflow policy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_event_counters;

  localparam int NE  = 4;
  localparam int NCH = NE + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NE-1:0] evt = '0;
  logic          freeze = 1'b0;
  logic          clr = 1'b0;
  logic          snap_req = 1'b0;
  logic [2:0]    sel = '0;

  logic          ack_a, ack_w, ack_s;
  logic [31:0]   rd_a;
  logic [3:0]    rd_w, rd_s;
  logic [NE:0]   ovf_a, ovf_w, ovf_s;

  pipe_event_counters #(.NUM_EVT(NE), .CNT_W(32), .SATURATE(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .freeze_i(freeze),
    .clr_i(clr), .snap_req_i(snap_req), .snap_ack_o(ack_a), .sel_i(sel),
    .rd_data_o(rd_a), .ovf_o(ovf_a));

  pipe_event_counters #(.NUM_EVT(NE), .CNT_W(4), .SATURATE(0)) u_dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .freeze_i(freeze),
    .clr_i(clr), .snap_req_i(snap_req), .snap_ack_o(ack_w), .sel_i(sel),
    .rd_data_o(rd_w), .ovf_o(ovf_w));

  pipe_event_counters #(.NUM_EVT(NE), .CNT_W(4), .SATURATE(1)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .freeze_i(freeze),
    .clr_i(clr), .snap_req_i(snap_req), .snap_ack_o(ack_s), .sel_i(sel),
    .rd_data_o(rd_s), .ovf_o(ovf_s));

  always #20 clk = ~clk;

  // Reference model: raw increment totals since the last clear/reset.
  longint tot     [NCH];
  longint shd_tot [NCH];
  logic   ack_m = 1'b0;
  bit     run   = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  int     scan  = 0;

  function automatic logic [63:0] exp_val(input longint t, input int w, input bit sat);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (sat) return (t > mx) ? mx : t;
    return t & mx;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [2:0] s, input int w, input bit sat);
    if (int'(s) > NE) return '0;
    return exp_val(shd_tot[s], w, sat);
  endfunction

  function automatic logic [63:0] exp_ovf(input int w);
    logic [63:0] o;
    longint mx;
    o  = '0;
    mx = (longint'(1) << w) - 1;
    for (int k = 0; k < NCH; k++) o[k] = (tot[k] > mx);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      tot[k]     = 0;
      shd_tot[k] = 0;
    end
    ack_m = 1'b0;
  endtask

  // One clock: inputs already driven; the model steps on the rising edge.
  task automatic cyc();
    bit a;
    bit en;
    sel  = 3'(scan % 8);
    scan = scan + 1;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      a = snap_req && !ack_m;
      if (a) for (int k = 0; k < NCH; k++) shd_tot[k] = tot[k];
      ack_m = a;
      for (int k = 0; k < NCH; k++) begin
        en = start && !freeze && ((k == 0) || evt[k-1]);
        if (clr)     tot[k] = 0;
        else if (en) tot[k] = tot[k] + 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic snap();
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (run) begin
      chk("ack_a", 64'(ack_a), 64'(ack_m));
      chk("ack_w", 64'(ack_w), 64'(ack_m));
      chk("ack_s", 64'(ack_s), 64'(ack_m));
      chk("ovf_a", 64'(ovf_a), exp_ovf(32));
      chk("ovf_w", 64'(ovf_w), exp_ovf(4));
      chk("ovf_s", 64'(ovf_s), exp_ovf(4));
      chk("rd_a",  64'(rd_a),  exp_rd(sel, 32, 1'b0));
      chk("rd_w",  64'(rd_w),  exp_rd(sel, 4, 1'b0));
      chk("rd_s",  64'(rd_s),  exp_rd(sel, 4, 1'b1));
    end
  end

  logic [3:0]  pat    [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0100,
                               4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
  logic [31:0] basic6 [6]  = '{32'd10, 32'd3, 32'd0, 32'd1, 32'd0, 32'd0};
  int          acks;

  initial begin
    model_clear();
    // Reset with start low for 5 cycles
    rst = 1'b1;
    cyc();
    run = 1'b1;
    cycles(4);
    rst = 1'b0;
    cyc();
    snap();
    chk("idle_ack_hi", 64'(ack_a), 64'd1);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      chk("idle_rd", 64'(rd_a), 64'd0);
    end
    cyc();
    chk("idle_ack_lo", 64'(ack_a), 64'd0);

    // Basic counting: 10 active cycles, evt[0] x3, evt[2] x1
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      evt = pat[i];
      cyc();
    end
    evt   = '0;
    start = 1'b0;
    snap();
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      #1;
      chk("basic_rd", 64'(rd_a), 64'(basic6[s]));
    end

    // Wrap / saturate at 4 bits: 17 active cycles
    clear();
    start = 1'b1;
    cycles(17);
    start = 1'b0;
    snap();
    sel = 3'd0;
    #1;
    chk("wrap_rd0", 64'(rd_w), 64'd1);
    chk("wrap_ovf", 64'(ovf_w), 64'b00001);
    chk("sat17_rd0", 64'(rd_s), 64'd15);

    // Saturate: 20 active cycles, then clear and recount
    clear();
    start = 1'b1;
    cycles(20);
    start = 1'b0;
    snap();
    sel = 3'd0;
    #1;
    chk("sat_rd0", 64'(rd_s), 64'd15);
    chk("sat_ovf", 64'(ovf_s), 64'b00001);
    clear();
    chk("sat_clr_ovf", 64'(ovf_s), 64'd0);
    start = 1'b1;
    evt   = 4'b1010;
    cycles(6);
    evt   = '0;
    start = 1'b0;
    snap();
    sel = 3'd0;
    #1;
    chk("sat_recount", 64'(rd_s), 64'd6);
    sel = 3'd4;
    #1;
    chk("sat_recount_ch4", 64'(rd_s), 64'd6);

    // Snapshot together with clear: interval boundary, no lost event
    clear();
    start = 1'b1;
    cycles(8);
    snap_req = 1'b1;
    clr      = 1'b1;
    cyc();
    snap_req = 1'b0;
    clr      = 1'b0;
    sel = 3'd0;
    #1;
    chk("snapclr_rd0", 64'(rd_a), 64'd8);
    cycles(5);
    start = 1'b0;
    snap();
    sel = 3'd0;
    #1;
    chk("snapclr_next", 64'(rd_a), 64'd5);
    chk("model_pin5", exp_rd(3'd0, 32, 1'b0), 64'd5);

    // Held request: one ack every other cycle
    cyc();
    snap_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("held_ack", 64'(ack_a), (i % 2 == 0) ? 64'd1 : 64'd0);
      if (ack_a) acks++;
    end
    snap_req = 1'b0;
    chk("held_ack_cnt", 64'(acks), 64'd3);

    // Freeze: counters hold even with events present
    cyc();
    clear();
    start = 1'b1;
    cycles(3);
    freeze = 1'b1;
    evt    = 4'b1111;
    cycles(4);
    snap();
    sel = 3'd0;
    #1;
    chk("freeze_rd0", 64'(rd_a), 64'd3);
    sel = 3'd2;
    #1;
    chk("freeze_rd2", 64'(rd_a), 64'd0);
    freeze = 1'b0;
    evt    = 4'b0110;
    cycles(3);
    evt    = '0;

    // Reset asserted during an ack cycle
    snap();
    chk("pre_rst_ack", 64'(ack_a), 64'd1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_ack", 64'(ack_a), 64'd0);
    chk("rst_ovf", 64'(ovf_w), 64'd0);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      chk("rst_rd", 64'(rd_a), 64'd0);
    end
    cycles(2);
    rst   = 1'b0;
    start = 1'b0;
    cycles(2);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
